id_ex_operand_stage: RTL and testbench
======================================

Name: id_ex_operand_stage

Overview:
- Operand-fetch stage that sits directly upstream of the ALU.
- Holds the 32-entry general register file and selects the two ALU operands from register data, immediates or the shift amount.
- Registers the operands together with the 3-bit ALU opcode into an ID/EX pipeline register that drives the ALU's a, b and ALUop inputs.
- Accepts writeback from the end of the pipe and supports stall and flush from hazard control.

Parameters:
- DATA_W, 32, datapath and register width.
- REG_ADDR_W, 5, register address width; the file holds 2**REG_ADDR_W entries.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  decoded instruction present this cycle.
- stall  input  1  hold the pipeline register.
- flush  input  1  insert a bubble.
- rs  input  REG_ADDR_W  source register A address.
- rt  input  REG_ADDR_W  source register B address.
- imm  input  16  instruction immediate.
- shamt  input  5  shift amount field.
- alu_op_in  input  3  decoded ALU opcode (000 add, 001 sub, 010 slt, 011 srl, 100 sll, 101 or, 110 and, 111 xor).
- a_sel  input  1  A operand source: 0 = rs data, 1 = rt data (shifts).
- b_sel  input  2  B operand source: 00 = rt data, 01 = sign-extended imm, 10 = zero-extended imm, 11 = zero-extended shamt.
- wb_en  input  1  register write enable.
- wb_addr  input  REG_ADDR_W  write address.
- wb_data  input  DATA_W  write data.
- alu_a  output  DATA_W  registered operand a to the ALU.
- alu_b  output  DATA_W  registered operand b to the ALU.
- alu_op  output  3  registered opcode to the ALU.
- rt_data  output  DATA_W  registered rt value (store data).
- ex_valid  output  1  registered valid for the EX stage.

Behaviour:
- **Register file write:** the file is written on the rising edge when wb_en=1 and wb_addr!=0.
  - Register 0 always reads 0; writes to it are discarded.
  - Writes occur regardless of stall and flush.
- **Register file read:** combinational from rs and rt, then muxed by a_sel and b_sel.
- **Immediate extension:**
  - Sign-extend replicates imm[15] into bits 31:16.
  - Zero-extend places 0 in bits 31:16.
  - shamt is zero-extended to DATA_W.
- **Pipeline register priority on each rising edge:** rst > flush > stall > load.
  - rst: regfile entries, alu_a, alu_b, rt_data all 0; alu_op=000; ex_valid=0. Reset takes effect on the edge even mid-stall or mid-flush.
  - flush: ex_valid=0, alu_a/alu_b/rt_data=0, alu_op=000. Flush overrides a simultaneous stall.
  - stall: all outputs hold their previous values, including ex_valid. Operands already held are not refreshed by a concurrent writeback; upstream hazard logic prevents this case.
  - load with in_valid=1: capture the selected operands, alu_op_in and rt data; ex_valid=1.
  - load with in_valid=0: bubble, with the same values as flush.
- **Latency:** one cycle from the ID inputs to the ALU inputs. A write committed at edge N is visible to reads after edge N without the optional feature.
- **Outputs during a bubble:** zero outputs give ALU result 0 and zero=1; EX logic qualifies them with ex_valid.
- **Width rule:** no arithmetic is performed here. All widths are exact and unused upper bits are 0.

Optional Feature:
- Macro WB_BYPASS_EN.
- Defined: a read whose address equals wb_addr while wb_en=1 and wb_addr!=0 returns wb_data in the same cycle (write-through), so the pipeline register captures the new value on the same edge as the write.
- Undefined: the read returns the old register contents during the write cycle, and the new value is seen from the next cycle.
- Register 0 never bypasses in either build.

Test Plan:
- **Reset:** assert rst for 2 cycles with stall=1 -> all outputs 0, ex_valid=0. After release, reading any register returns 0.
- **Register operands:**
  - Stimulus: write r3=0x0000_0005 and r4=0xFFFF_FFF0, then issue rs=3, rt=4, b_sel=00, a_sel=0, alu_op_in=001, in_valid=1.
  - Response, next cycle: alu_a=0x5, alu_b=0xFFFF_FFF0, alu_op=001, rt_data=0xFFFF_FFF0, ex_valid=1.
- **Immediate and shift selects:**
  - imm=0x8001 with b_sel=01 -> alu_b=0xFFFF_8001.
  - imm=0x8001 with b_sel=10 -> alu_b=0x0000_8001.
  - a_sel=1, rt=4, b_sel=11, shamt=7 -> alu_a=0xFFFF_FFF0, alu_b=0x7.
- **Register 0:** write 0xDEAD_BEEF to r0, then read rs=0 -> alu_a=0.
- **Stall, then flush:**
  - Load an instruction, then raise stall for 3 cycles while the inputs change -> outputs are unchanged for all 3 cycles.
  - Assert stall=1 and flush=1 together -> ex_valid=0 and operands 0 on the next edge.
- **Same-cycle write and read:**
  - Stimulus: wb_en=1, wb_addr=7, wb_data=0x1234; in the same cycle rs=7, in_valid=1; r7 previously held 0x9.
  - With WB_BYPASS_EN: alu_a=0x1234.
  - Without WB_BYPASS_EN: alu_a=0x9, and alu_a=0x1234 on re-issue the following cycle.

Source files
------------

// File: rtl/id_ex_operand_stage_if.sv
// Bus bundle for the ID/EX operand stage: decoded-instruction inputs, writeback port and ALU-side outputs.
// The master drives the decode and writeback signals; the slave (the stage) drives the ALU operands.
interface id_ex_operand_stage_if #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5
);
  logic                  in_valid;
  logic                  stall;
  logic                  flush;
  logic [REG_ADDR_W-1:0] rs;
  logic [REG_ADDR_W-1:0] rt;
  logic [15:0]           imm;
  logic [4:0]            shamt;
  logic [2:0]            alu_op_in;
  logic                  a_sel;
  logic [1:0]            b_sel;
  logic                  wb_en;
  logic [REG_ADDR_W-1:0] wb_addr;
  logic [DATA_W-1:0]     wb_data;
  logic [DATA_W-1:0]     alu_a;
  logic [DATA_W-1:0]     alu_b;
  logic [2:0]            alu_op;
  logic [DATA_W-1:0]     rt_data;
  logic                  ex_valid;

  modport master (
    output in_valid, stall, flush, rs, rt, imm, shamt, alu_op_in, a_sel, b_sel,
           wb_en, wb_addr, wb_data,
    input  alu_a, alu_b, alu_op, rt_data, ex_valid
  );

  modport slave (
    input  in_valid, stall, flush, rs, rt, imm, shamt, alu_op_in, a_sel, b_sel,
           wb_en, wb_addr, wb_data,
    output alu_a, alu_b, alu_op, rt_data, ex_valid
  );
endinterface

// File: rtl/id_ex_operand_stage.sv
// Operand-fetch stage: register file, operand muxing and the ID/EX pipeline register feeding the ALU.
// Optional macro WB_BYPASS_EN makes a same-cycle writeback visible to the reads (write-through).
module id_ex_operand_stage #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5
) (
  input logic                  clk,
  input logic                  rst,
  id_ex_operand_stage_if.slave bus
);
  localparam int NUM_REGS = 2 ** REG_ADDR_W;

  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] regs_d [NUM_REGS];

  logic [DATA_W-1:0] rs_val;
  logic [DATA_W-1:0] rt_val;
  logic [DATA_W-1:0] a_mux;
  logic [DATA_W-1:0] b_mux;

  logic [DATA_W-1:0] alu_a_q, alu_a_d;
  logic [DATA_W-1:0] alu_b_q, alu_b_d;
  logic [DATA_W-1:0] rt_data_q, rt_data_d;
  logic [2:0]        alu_op_q, alu_op_d;
  logic              ex_valid_q, ex_valid_d;

  logic wb_hit_ok;
  assign wb_hit_ok = bus.wb_en && (bus.wb_addr != '0);

  // Writeback ignores stall/flush; entry 0 is never written so it stays at its reset value of 0.
  always_comb begin
    regs_d = regs_q;
    if (wb_hit_ok) begin
      regs_d[bus.wb_addr] = bus.wb_data;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_REGS; i++) begin
      if (rst) begin
        regs_q[i] <= '0;
      end else begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  always_comb begin
    rs_val = regs_q[bus.rs];
`ifdef WB_BYPASS_EN
    if (wb_hit_ok && (bus.wb_addr == bus.rs)) begin
      rs_val = bus.wb_data;
    end
`endif
    if (bus.rs == '0) begin
      rs_val = '0;
    end
  end

  always_comb begin
    rt_val = regs_q[bus.rt];
`ifdef WB_BYPASS_EN
    if (wb_hit_ok && (bus.wb_addr == bus.rt)) begin
      rt_val = bus.wb_data;
    end
`endif
    if (bus.rt == '0) begin
      rt_val = '0;
    end
  end

  always_comb begin
    a_mux = bus.a_sel ? rt_val : rs_val;
    unique case (bus.b_sel)
      2'b00:   b_mux = rt_val;
      2'b01:   b_mux = {{(DATA_W-16){bus.imm[15]}}, bus.imm};
      2'b10:   b_mux = {{(DATA_W-16){1'b0}}, bus.imm};
      default: b_mux = {{(DATA_W-5){1'b0}}, bus.shamt};
    endcase
  end

  // Flush (or a load without a valid instruction) inserts an all-zero bubble; stall holds everything.
  always_comb begin
    alu_a_d    = alu_a_q;
    alu_b_d    = alu_b_q;
    rt_data_d  = rt_data_q;
    alu_op_d   = alu_op_q;
    ex_valid_d = ex_valid_q;
    if (bus.flush || (!bus.stall && !bus.in_valid)) begin
      alu_a_d    = '0;
      alu_b_d    = '0;
      rt_data_d  = '0;
      alu_op_d   = 3'b000;
      ex_valid_d = 1'b0;
    end else if (!bus.stall) begin
      alu_a_d    = a_mux;
      alu_b_d    = b_mux;
      rt_data_d  = rt_val;
      alu_op_d   = bus.alu_op_in;
      ex_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      rt_data_q  <= '0;
      alu_op_q   <= 3'b000;
      ex_valid_q <= 1'b0;
    end else begin
      alu_a_q    <= alu_a_d;
      alu_b_q    <= alu_b_d;
      rt_data_q  <= rt_data_d;
      alu_op_q   <= alu_op_d;
      ex_valid_q <= ex_valid_d;
    end
  end

  assign bus.alu_a    = alu_a_q;
  assign bus.alu_b    = alu_b_q;
  assign bus.rt_data  = rt_data_q;
  assign bus.alu_op   = alu_op_q;
  assign bus.ex_valid = ex_valid_q;
endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Directed bench for id_ex_operand_stage: a vector table for single-cycle behaviour plus
// hand-written stall/flush/reset sequences. Expectations for the same-cycle read follow WB_BYPASS_EN.
module tb_id_ex_operand_stage;
  logic clk;
  logic rst;
  int   checks;
  int   failures;

  id_ex_operand_stage_if #(.DATA_W(32), .REG_ADDR_W(5)) bus ();

  id_ex_operand_stage #(.DATA_W(32), .REG_ADDR_W(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

`ifdef WB_BYPASS_EN
  localparam logic [31:0] SAME_CYCLE_A = 32'h0000_1234;
`else
  localparam logic [31:0] SAME_CYCLE_A = 32'h0000_0009;
`endif

  typedef struct {
    string       name;
    logic        in_valid;
    logic        stall;
    logic        flush;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [15:0] imm;
    logic [4:0]  shamt;
    logic [2:0]  op;
    logic        a_sel;
    logic [1:0]  b_sel;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic [31:0] exp_a;
    logic [31:0] exp_b;
    logic [2:0]  exp_op;
    logic [31:0] exp_rt;
    logic        exp_valid;
  } vec_t;

  localparam int NUM_VECS = 12;
  vec_t vecs [NUM_VECS];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic setIdle();
    bus.in_valid  = 1'b0;
    bus.stall     = 1'b0;
    bus.flush     = 1'b0;
    bus.rs        = '0;
    bus.rt        = '0;
    bus.imm       = '0;
    bus.shamt     = '0;
    bus.alu_op_in = '0;
    bus.a_sel     = 1'b0;
    bus.b_sel     = 2'b00;
    bus.wb_en     = 1'b0;
    bus.wb_addr   = '0;
    bus.wb_data   = '0;
  endtask

  task automatic applyStimulus(input vec_t v);
    bus.in_valid  = v.in_valid;
    bus.stall     = v.stall;
    bus.flush     = v.flush;
    bus.rs        = v.rs;
    bus.rt        = v.rt;
    bus.imm       = v.imm;
    bus.shamt     = v.shamt;
    bus.alu_op_in = v.op;
    bus.a_sel     = v.a_sel;
    bus.b_sel     = v.b_sel;
    bus.wb_en     = v.wb_en;
    bus.wb_addr   = v.wb_addr;
    bus.wb_data   = v.wb_data;
  endtask

  task automatic checkField(input string name, input string field,
                            input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s.%s actual=0x%08h required=0x%08h", name, field, act, exp);
    end
  endtask

  task automatic checkOutput(input string name, input logic [31:0] exp_a, input logic [31:0] exp_b,
                             input logic [2:0] exp_op, input logic [31:0] exp_rt, input logic exp_valid);
    checkField(name, "alu_a", bus.alu_a, exp_a);
    checkField(name, "alu_b", bus.alu_b, exp_b);
    checkField(name, "alu_op", {29'd0, bus.alu_op}, {29'd0, exp_op});
    checkField(name, "rt_data", bus.rt_data, exp_rt);
    checkField(name, "ex_valid", {31'd0, bus.ex_valid}, {31'd0, exp_valid});
  endtask

  initial begin
    checks   = 0;
    failures = 0;

    //            name          iv   st   fl   rs    rt    imm       sh    op    as   bs     we   wa    wdata          exp_a          exp_b          eop   exp_rt         ev
    vecs[0]  = '{"wr_r3",       1'b0,1'b0,1'b0,5'd0, 5'd0, 16'h0000, 5'd0, 3'd0, 1'b0,2'b00, 1'b1,5'd3, 32'h0000_0005, 32'h0,         32'h0,         3'd0, 32'h0,         1'b0};
    vecs[1]  = '{"wr_r4",       1'b0,1'b0,1'b0,5'd0, 5'd0, 16'h0000, 5'd0, 3'd0, 1'b0,2'b00, 1'b1,5'd4, 32'hFFFF_FFF0, 32'h0,         32'h0,         3'd0, 32'h0,         1'b0};
    vecs[2]  = '{"reg_ops",     1'b1,1'b0,1'b0,5'd3, 5'd4, 16'h0000, 5'd0, 3'd1, 1'b0,2'b00, 1'b1,5'd7, 32'h0000_0009, 32'h0000_0005, 32'hFFFF_FFF0, 3'd1, 32'hFFFF_FFF0, 1'b1};
    vecs[3]  = '{"imm_sext",    1'b1,1'b0,1'b0,5'd3, 5'd0, 16'h8001, 5'd0, 3'd0, 1'b0,2'b01, 1'b0,5'd0, 32'h0,         32'h0000_0005, 32'hFFFF_8001, 3'd0, 32'h0,         1'b1};
    vecs[4]  = '{"imm_zext",    1'b1,1'b0,1'b0,5'd3, 5'd0, 16'h8001, 5'd0, 3'd5, 1'b0,2'b10, 1'b0,5'd0, 32'h0,         32'h0000_0005, 32'h0000_8001, 3'd5, 32'h0,         1'b1};
    vecs[5]  = '{"shamt",       1'b1,1'b0,1'b0,5'd0, 5'd4, 16'h0000, 5'd7, 3'd3, 1'b1,2'b11, 1'b0,5'd0, 32'h0,         32'hFFFF_FFF0, 32'h0000_0007, 3'd3, 32'hFFFF_FFF0, 1'b1};
    vecs[6]  = '{"wr_r0",       1'b0,1'b0,1'b0,5'd0, 5'd0, 16'h0000, 5'd0, 3'd0, 1'b0,2'b00, 1'b1,5'd0, 32'hDEAD_BEEF, 32'h0,         32'h0,         3'd0, 32'h0,         1'b0};
    vecs[7]  = '{"rd_r0",       1'b1,1'b0,1'b0,5'd0, 5'd0, 16'h0000, 5'd0, 3'd6, 1'b0,2'b00, 1'b0,5'd0, 32'h0,         32'h0,         32'h0,         3'd6, 32'h0,         1'b1};
    vecs[8]  = '{"same_cycle",  1'b1,1'b0,1'b0,5'd7, 5'd0, 16'h0001, 5'd0, 3'd0, 1'b0,2'b01, 1'b1,5'd7, 32'h0000_1234, SAME_CYCLE_A,  32'h0000_0001, 3'd0, 32'h0,         1'b1};
    vecs[9]  = '{"reissue",     1'b1,1'b0,1'b0,5'd7, 5'd0, 16'h0001, 5'd0, 3'd0, 1'b0,2'b01, 1'b0,5'd0, 32'h0,         32'h0000_1234, 32'h0000_0001, 3'd0, 32'h0,         1'b1};
    vecs[10] = '{"rd_r31",      1'b1,1'b0,1'b0,5'd31,5'd31,16'h0000, 5'd0, 3'd7, 1'b0,2'b00, 1'b0,5'd0, 32'h0,         32'h0,         32'h0,         3'd7, 32'h0,         1'b1};
    vecs[11] = '{"flush",       1'b1,1'b0,1'b1,5'd3, 5'd4, 16'h0000, 5'd0, 3'd2, 1'b0,2'b00, 1'b0,5'd0, 32'h0,         32'h0,         32'h0,         3'd0, 32'h0,         1'b0};

    setIdle();
    rst       = 1'b1;
    bus.stall = 1'b1;
    tick();
    tick();
    checkOutput("reset", 32'h0, 32'h0, 3'd0, 32'h0, 1'b0);
    rst = 1'b0;
    setIdle();

    for (int i = 0; i < NUM_VECS; i++) begin
      applyStimulus(vecs[i]);
      tick();
      checkOutput(vecs[i].name, vecs[i].exp_a, vecs[i].exp_b, vecs[i].exp_op, vecs[i].exp_rt, vecs[i].exp_valid);
    end

    // Stall holds outputs for three cycles while inputs change; a writeback still lands.
    setIdle();
    bus.in_valid  = 1'b1;
    bus.rs        = 5'd3;
    bus.rt        = 5'd4;
    bus.alu_op_in = 3'd2;
    tick();
    checkOutput("stall_load", 32'h5, 32'hFFFF_FFF0, 3'd2, 32'hFFFF_FFF0, 1'b1);
    for (int c = 0; c < 3; c++) begin
      bus.stall     = 1'b1;
      bus.in_valid  = c[0];
      bus.rs        = 5'd7;
      bus.rt        = 5'd0;
      bus.b_sel     = 2'b01;
      bus.imm       = 16'h1111;
      bus.alu_op_in = 3'd5;
      bus.wb_en     = (c == 1);
      bus.wb_addr   = 5'd5;
      bus.wb_data   = 32'h0000_0055;
      tick();
      checkOutput($sformatf("stall_hold%0d", c), 32'h5, 32'hFFFF_FFF0, 3'd2, 32'hFFFF_FFF0, 1'b1);
    end

    setIdle();
    bus.stall    = 1'b1;
    bus.flush    = 1'b1;
    bus.in_valid = 1'b1;
    bus.rs       = 5'd3;
    tick();
    checkOutput("stall_flush", 32'h0, 32'h0, 3'd0, 32'h0, 1'b0);

    setIdle();
    bus.in_valid  = 1'b1;
    bus.rs        = 5'd5;
    bus.rt        = 5'd3;
    bus.alu_op_in = 3'd4;
    tick();
    checkOutput("wb_during_stall", 32'h55, 32'h5, 3'd4, 32'h5, 1'b1);

    // Reset mid-stall clears the pipeline register and the register file.
    bus.stall = 1'b1;
    rst       = 1'b1;
    tick();
    checkOutput("reset_mid_stall", 32'h0, 32'h0, 3'd0, 32'h0, 1'b0);
    rst = 1'b0;
    setIdle();
    bus.in_valid  = 1'b1;
    bus.rs        = 5'd3;
    bus.rt        = 5'd4;
    bus.alu_op_in = 3'd1;
    tick();
    checkOutput("regs_after_reset", 32'h0, 32'h0, 3'd1, 32'h0, 1'b1);

    setIdle();
    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
